// File: rtl/climate_event_monitor.sv
// Purpose : statistics, circular verdict history and storm-alarm FSM fed by the climate classifier.
// Latency : a done sample in cycle t shows in counters/log/storm_run/storm_alarm from t+1; pops return data at t+1.
// Backpres: none; every done pulse is accepted, and a full log overwrites its oldest entry.
// Ports   : clk/rst (sync, active-high); done + snow/sunny/storm/error verdict flags; clr_stats, alarm_ack, hist_rd_en;
//           hist_rd_data/hist_rd_valid/hist_count log read side; cnt_* counters, cnt_sat/hist_ovf sticky flags;
//           storm_alarm latched alarm, storm_run current consecutive-storm count.
module climate_event_monitor #(
   parameter int CNT_W      = 16,
   parameter int STORM_RUN  = 3,
   parameter int HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          done,
   input  logic                          snow,
   input  logic                          sunny,
   input  logic                          storm,
   input  logic                          error,
   input  logic                          clr_stats,
   input  logic                          alarm_ack,
   input  logic                          hist_rd_en,
   output logic [2:0]                    hist_rd_data,
   output logic                          hist_rd_valid,
   output logic [$clog2(HIST_DEPTH):0]   hist_count,
   output logic [CNT_W-1:0]              cnt_snow,
   output logic [CNT_W-1:0]              cnt_sunny,
   output logic [CNT_W-1:0]              cnt_storm,
   output logic [CNT_W-1:0]              cnt_error,
   output logic [CNT_W-1:0]              cnt_total,
   output logic                          cnt_sat,
   output logic                          hist_ovf,
   output logic                          storm_alarm,
   output logic [7:0]                    storm_run
);

   localparam int PTR_W = $clog2(HIST_DEPTH);
   localparam int HC_W  = PTR_W + 1;
   localparam logic [HC_W-1:0]  HIST_FULL = HC_W'(HIST_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [7:0]       RUN_TGT   = 8'(STORM_RUN);

   localparam logic [2:0] C_NONE  = 3'd0;
   localparam logic [2:0] C_SNOW  = 3'd1;
   localparam logic [2:0] C_SUNNY = 3'd2;
   localparam logic [2:0] C_STORM = 3'd3;
   localparam logic [2:0] C_ERR   = 3'd4;
   localparam logic [2:0] C_MULTI = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ALARM} state_t;

   // ---------------- verdict encoding ----------------
   logic [1:0] n_flags;
   logic [2:0] code;

   always_comb begin
      n_flags = 2'(snow) + 2'(sunny) + 2'(storm);
      code    = C_NONE;
      if (error)
         code = C_ERR;
      else if (n_flags == 2'd1)
         code = snow ? C_SNOW : (sunny ? C_SUNNY : C_STORM);
      else if (n_flags != 2'd0)
         code = C_MULTI;
   end

   // ---------------- statistics ----------------
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != CNT_MAX) ? v + 1'b1 : v;
   endfunction

   // clr_stats acts before the sample, so a same-cycle done counts from zero.
   logic [CNT_W-1:0] base_snow, base_sunny, base_storm, base_error, base_total;
   logic             inc_snow, inc_sunny, inc_storm, inc_error;
   logic             sat_hit;

   always_comb begin
      base_snow  = clr_stats ? '0 : cnt_snow;
      base_sunny = clr_stats ? '0 : cnt_sunny;
      base_storm = clr_stats ? '0 : cnt_storm;
      base_error = clr_stats ? '0 : cnt_error;
      base_total = clr_stats ? '0 : cnt_total;
      inc_snow   = done && (code == C_SNOW);
      inc_sunny  = done && (code == C_SUNNY);
      inc_storm  = done && (code == C_STORM);
      inc_error  = done && ((code == C_ERR) || (code == C_MULTI));
      // sticky flag marks an increment that had to be clamped
      sat_hit    = (inc_snow  && base_snow  == CNT_MAX) ||
                   (inc_sunny && base_sunny == CNT_MAX) ||
                   (inc_storm && base_storm == CNT_MAX) ||
                   (inc_error && base_error == CNT_MAX) ||
                   (done      && base_total == CNT_MAX);
   end

   // ---------------- history log ----------------
   logic [2:0]       mem [HIST_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             hist_full, do_rd, do_wr, ovf_hit;

   always_comb begin
      hist_full = (hist_count == HIST_FULL);
      do_rd     = hist_rd_en && (hist_count != '0);
      do_wr     = done;
      // a pop in the same cycle frees the slot, so only an unpaired write overwrites
      ovf_hit   = do_wr && !do_rd && hist_full;
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_snow      <= '0;
         cnt_sunny     <= '0;
         cnt_storm     <= '0;
         cnt_error     <= '0;
         cnt_total     <= '0;
         cnt_sat       <= 1'b0;
         hist_ovf      <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         hist_count    <= '0;
         hist_rd_data  <= '0;
         hist_rd_valid <= 1'b0;
      end else begin
         cnt_snow      <= bump(base_snow,  inc_snow);
         cnt_sunny     <= bump(base_sunny, inc_sunny);
         cnt_storm     <= bump(base_storm, inc_storm);
         cnt_error     <= bump(base_error, inc_error);
         cnt_total     <= bump(base_total, done);
         cnt_sat       <= (cnt_sat  && !clr_stats) || sat_hit;
         hist_ovf      <= (hist_ovf && !clr_stats) || ovf_hit;
         hist_rd_valid <= do_rd;
         if (do_rd)
            hist_rd_data <= mem[rd_ptr];
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd || ovf_hit)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd && !hist_full)
            hist_count <= hist_count + 1'b1;
         else if (do_rd && !do_wr)
            hist_count <= hist_count - 1'b1;
      end
   end

   // ---------------- storm alarm FSM ----------------
   state_t     state_q, state_d, eff_state;
   logic [7:0] run_d, eff_run, run_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         storm_run <= '0;
      end else begin
         state_q   <= state_d;
         storm_run <= run_d;
      end
   end

   always_comb begin
      // acknowledge is applied first; the sample is then judged from the resulting state
      eff_state = state_q;
      eff_run   = storm_run;
      if (alarm_ack && state_q == S_ALARM) begin
         eff_state = S_IDLE;
         eff_run   = '0;
      end
      run_inc = (eff_run == 8'hFF) ? eff_run : eff_run + 1'b1;
      state_d = eff_state;
      run_d   = eff_run;
      if (done) begin
         if (code == C_STORM) begin
            run_d = run_inc;
            if (eff_state != S_ALARM)
               state_d = (run_inc >= RUN_TGT) ? S_ALARM : S_RUN;
         end else begin
            run_d = '0;
            if (eff_state != S_ALARM)
               state_d = S_IDLE;
         end
      end
   end

   always_comb begin
      storm_alarm = (state_q == S_ALARM);
   end

endmodule

// File: tb/tb_climate_event_monitor.sv
// Purpose : directed self-checking bench for climate_event_monitor (CNT_W=4, STORM_RUN=3, HIST_DEPTH=8).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpres: not applicable.
module tb_climate_event_monitor;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             done = 1'b0, snow = 1'b0, sunny = 1'b0, storm = 1'b0, error = 1'b0;
   logic             clr_stats = 1'b0, alarm_ack = 1'b0, hist_rd_en = 1'b0;
   logic [2:0]       hist_rd_data;
   logic             hist_rd_valid;
   logic [3:0]       hist_count;
   logic [CNT_W-1:0] cnt_snow, cnt_sunny, cnt_storm, cnt_error, cnt_total;
   logic             cnt_sat, hist_ovf, storm_alarm;
   logic [7:0]       storm_run;

   int n_checks = 0;
   int n_errors = 0;

   climate_event_monitor #(.CNT_W(CNT_W), .STORM_RUN(3), .HIST_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .done(done), .snow(snow), .sunny(sunny), .storm(storm), .error(error),
      .clr_stats(clr_stats), .alarm_ack(alarm_ack), .hist_rd_en(hist_rd_en),
      .hist_rd_data(hist_rd_data), .hist_rd_valid(hist_rd_valid), .hist_count(hist_count),
      .cnt_snow(cnt_snow), .cnt_sunny(cnt_sunny), .cnt_storm(cnt_storm), .cnt_error(cnt_error),
      .cnt_total(cnt_total), .cnt_sat(cnt_sat), .hist_ovf(hist_ovf),
      .storm_alarm(storm_alarm), .storm_run(storm_run)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_raw(input logic s, input logic y, input logic t, input logic e);
      snow = s; sunny = y; storm = t; error = e; done = 1'b1;
      step();
      snow = 1'b0; sunny = 1'b0; storm = 1'b0; error = 1'b0; done = 1'b0;
   endtask

   task automatic put(input int c);
      case (c)
         1:       drive_raw(1'b1, 1'b0, 1'b0, 1'b0);
         2:       drive_raw(1'b0, 1'b1, 1'b0, 1'b0);
         3:       drive_raw(1'b0, 1'b0, 1'b1, 1'b0);
         4:       drive_raw(1'b0, 1'b0, 1'b0, 1'b1);
         5:       drive_raw(1'b1, 1'b0, 1'b1, 1'b0);
         default: drive_raw(1'b0, 1'b0, 1'b0, 1'b0);
      endcase
   endtask

   task automatic pop_expect(input string tag, input int exp);
      hist_rd_en = 1'b1;
      step();
      hist_rd_en = 1'b0;
      check({tag, "_vld"}, 32'(hist_rd_valid), 32'd1);
      check({tag, "_dat"}, 32'(hist_rd_data), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_snow"},  32'(cnt_snow),      0);
      check({tag, "_total"}, 32'(cnt_total),     0);
      check({tag, "_err"},   32'(cnt_error),     0);
      check({tag, "_count"}, 32'(hist_count),    0);
      check({tag, "_vld"},   32'(hist_rd_valid), 0);
      check({tag, "_dat"},   32'(hist_rd_data),  0);
      check({tag, "_sat"},   32'(cnt_sat),       0);
      check({tag, "_ovf"},   32'(hist_ovf),      0);
      check({tag, "_alarm"}, 32'(storm_alarm),   0);
      check({tag, "_run"},   32'(storm_run),     0);
   endtask

   int codes_a [5]  = '{1, 2, 3, 0, 4};
   int codes_w [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
   int pops_w  [8]  = '{3, 1, 2, 3, 1, 2, 3, 1};
   int storms  [6]  = '{3, 3, 2, 3, 3, 3};
   int runs    [6]  = '{1, 2, 0, 1, 2, 3};
   int alarms  [6]  = '{0, 0, 0, 0, 0, 1};
   int pops_f  [8]  = '{2, 1, 2, 1, 2, 1, 2, 3};

   initial begin
      // reset state
      step();
      do_reset();
      check_all_zero("rst");

      // basic class counting and log order
      for (int i = 0; i < 5; i++) put(codes_a[i]);
      check("t1_snow",  32'(cnt_snow),   1);
      check("t1_sunny", 32'(cnt_sunny),  1);
      check("t1_storm", 32'(cnt_storm),  1);
      check("t1_err",   32'(cnt_error),  1);
      check("t1_total", 32'(cnt_total),  5);
      check("t1_count", 32'(hist_count), 5);
      // done=0 has no effect even with flags raised
      snow = 1'b1; step(); snow = 1'b0;
      check("t1_nodone", 32'(cnt_snow), 1);
      for (int i = 0; i < 5; i++) pop_expect($sformatf("t1_pop%0d", i), codes_a[i]);
      step();
      check("t1_vld_drop", 32'(hist_rd_valid), 0);
      check("t1_dat_hold", 32'(hist_rd_data),  4);
      check("t1_empty",    32'(hist_count),    0);
      hist_rd_en = 1'b1; step(); hist_rd_en = 1'b0;
      check("t1_empty_pop", 32'(hist_rd_valid), 0);

      // precedence of flags
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      check("t2_clr_total", 32'(cnt_total), 0);
      drive_raw(1'b1, 1'b0, 1'b0, 1'b1);
      drive_raw(1'b1, 1'b0, 1'b1, 1'b0);
      check("t2_err",   32'(cnt_error), 2);
      check("t2_snow",  32'(cnt_snow),  0);
      check("t2_storm", 32'(cnt_storm), 0);
      pop_expect("t2_pop_err",   4);
      pop_expect("t2_pop_multi", 5);

      // storm alarm FSM
      for (int i = 0; i < 6; i++) begin
         put(storms[i]);
         check($sformatf("t3_run%0d", i),   32'(storm_run),   32'(runs[i]));
         check($sformatf("t3_alarm%0d", i), 32'(storm_alarm), 32'(alarms[i]));
      end
      put(3);
      check("t3_hold_alarm", 32'(storm_alarm), 1);
      check("t3_hold_run",   32'(storm_run),   4);
      alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
      check("t3_ack_alarm", 32'(storm_alarm), 0);
      check("t3_ack_run",   32'(storm_run),   0);
      // ack outside ALARM is ignored
      alarm_ack = 1'b1; put(3); alarm_ack = 1'b0;
      check("t3_idle_ack_run", 32'(storm_run), 1);
      put(3); put(3);
      check("t3_realarm", 32'(storm_alarm), 1);
      // ack with a storm sample in the same cycle: new run of 1
      alarm_ack = 1'b1; put(3); alarm_ack = 1'b0;
      check("t3_ackdone_alarm", 32'(storm_alarm), 0);
      check("t3_ackdone_run",   32'(storm_run),   1);
      put(0);
      check("t3_none_clr", 32'(storm_run), 0);

      // log overflow
      do_reset();
      for (int i = 0; i < 8; i++) put(codes_w[i]);
      check("t4_full_count", 32'(hist_count), 8);
      check("t4_full_noovf", 32'(hist_ovf),   0);
      put(codes_w[8]); put(codes_w[9]);
      check("t4_ovf_count", 32'(hist_count), 8);
      check("t4_ovf",       32'(hist_ovf),   1);
      for (int i = 0; i < 8; i++) pop_expect($sformatf("t4_pop%0d", i), pops_w[i]);
      hist_rd_en = 1'b1; step(); hist_rd_en = 1'b0;
      check("t4_pop9_vld", 32'(hist_rd_valid), 0);
      check("t4_pop9_cnt", 32'(hist_count),    0);

      // empty read plus write, then full read plus write
      do_reset();
      hist_rd_en = 1'b1; put(1); hist_rd_en = 1'b0;
      check("t4b_emptyrw_vld", 32'(hist_rd_valid), 0);
      check("t4b_emptyrw_cnt", 32'(hist_count),    1);
      for (int i = 0; i < 7; i++) put((i % 2 == 0) ? 2 : 1);
      check("t4b_full", 32'(hist_count), 8);
      hist_rd_en = 1'b1; put(3); hist_rd_en = 1'b0;
      check("t4b_rw_vld", 32'(hist_rd_valid), 1);
      check("t4b_rw_dat", 32'(hist_rd_data),  1);
      check("t4b_rw_cnt", 32'(hist_count),    8);
      check("t4b_rw_ovf", 32'(hist_ovf),      0);
      for (int i = 0; i < 8; i++) pop_expect($sformatf("t4b_pop%0d", i), pops_f[i]);

      // counter saturation and clear-with-count
      do_reset();
      for (int i = 0; i < 15; i++) put(1);
      check("t5_snow15", 32'(cnt_snow), 15);
      put(1); put(1);
      check("t5_snow_sat",  32'(cnt_snow),  15);
      check("t5_total_sat", 32'(cnt_total), 15);
      check("t5_sat",       32'(cnt_sat),   1);
      clr_stats = 1'b1; put(1); clr_stats = 1'b0;
      check("t5_clr_snow",  32'(cnt_snow),   1);
      check("t5_clr_total", 32'(cnt_total),  1);
      check("t5_clr_sat",   32'(cnt_sat),    0);
      check("t5_clr_log",   32'(hist_count), 8);
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      check("t5_clr_ovf",   32'(hist_ovf),   0);
      check("t5_clr_log2",  32'(hist_count), 8);

      // reset while alarmed with a full log and a pending read
      put(3); put(3); put(3);
      check("t6_pre_alarm", 32'(storm_alarm), 1);
      check("t6_pre_full",  32'(hist_count),  8);
      hist_rd_en = 1'b1; rst = 1'b1; put(3); rst = 1'b0; hist_rd_en = 1'b0;
      check_all_zero("t6_rst");
      put(3);
      check("t6_new_run",   32'(storm_run),   1);
      check("t6_new_alarm", 32'(storm_alarm), 0);
      check("t6_new_count", 32'(hist_count),  1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
